imem_dmem_port_arbiter: RTL and testbench

- Shares one single-ported unified instruction/data memory between the instruction fetch path and the load/store path.
- Grants one requester per transaction and forwards its request to memory.
- Routes the memory response back to the owner.
- Data accesses have priority; a starvation counter guarantees fetch forward progress.

---
 rtl/imem_dmem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_imem_dmem_port_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// imem_dmem_port_arbiter
//
// Shares a single-ported unified instruction/data memory between the
// instruction fetch path and the load/store path. One requester owns the
// memory per transaction; its request is registered onto the mem_* bus and
// the memory response is routed back to that owner only.
//
// Data accesses win arbitration, but once MAX_DATA_BURST data grants have
// been issued back to back while a fetch was waiting, the next IDLE cycle
// with a pending fetch grants the fetch.
//
// States:
//   IDLE   | no transaction in flight, grants may be issued
//   BUSY_I | fetch owns the memory, waiting for mem_ready_i
//   BUSY_D | load/store owns the memory, waiting for mem_ready_i
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   if_*            fetch requester: req/addr in, gnt/rvalid/rdata out
//   d_*             data requester: req/we/be/addr/wdata in,
//                   gnt/rvalid/rdata out
//   mem_*           memory bus: registered req/we/be/addr/wdata out,
//                   ready/rdata in
//   busy_o          a transaction is in flight
// ---------------------------------------------------------------------------
module imem_dmem_port_arbiter #(
  parameter int XLEN           = 32,
  parameter int PC_WIDTH       = 32,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                if_req_i,
  input  logic [PC_WIDTH-1:0] if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [XLEN-1:0]     if_rdata_o,

  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [3:0]          d_be_i,
  input  logic [XLEN-1:0]     d_addr_i,
  input  logic [XLEN-1:0]     d_wdata_i,
  output logic                d_gnt_o,
  output logic                d_rvalid_o,
  output logic [XLEN-1:0]     d_rdata_o,

  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [3:0]          mem_be_o,
  output logic [XLEN-1:0]     mem_addr_o,
  output logic [XLEN-1:0]     mem_wdata_o,
  input  logic                mem_ready_i,
  input  logic [XLEN-1:0]     mem_rdata_i,

  output logic                busy_o
);

  localparam int CW = $clog2(MAX_DATA_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DATA_BURST);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] starve_cnt;
  logic          idle;
  logic          fetch_forced;

  assign idle         = (state == IDLE);
  assign fetch_forced = (starve_cnt == MAX_CNT);

  // Grants are combinational pulses in IDLE only. They are also masked by
  // rst so that every output reads zero while reset is held.
  assign d_gnt_o  = !rst && idle && d_req_i && !(if_req_i && fetch_forced);
  assign if_gnt_o = !rst && idle && if_req_i && (!d_req_i || fetch_forced);

  // Response routing: only the owner sees mem_ready_i, and rdata is zero
  // whenever the matching rvalid is low.
  assign if_rvalid_o = (state == BUSY_I) && mem_ready_i;
  assign d_rvalid_o  = (state == BUSY_D) && mem_ready_i;
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
  assign d_rdata_o   = d_rvalid_o  ? mem_rdata_i : '0;

  assign busy_o = !idle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_gnt_o) begin
            state       <= BUSY_D;
            mem_req_o   <= 1'b1;
            mem_we_o    <= d_we_i;
            mem_be_o    <= d_be_i;
            mem_addr_o  <= d_addr_i;
            mem_wdata_o <= d_wdata_i;
            // Count data grants that bypassed a waiting fetch; a data
            // grant with no fetch waiting restarts the burst window.
            if (if_req_i) begin
              if (!fetch_forced) begin
                starve_cnt <= starve_cnt + CW'(1);
              end
            end else begin
              starve_cnt <= '0;
            end
          end else if (if_gnt_o) begin
            state       <= BUSY_I;
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_be_o    <= 4'b1111;
            mem_addr_o  <= XLEN'(if_addr_i);
            mem_wdata_o <= '0;
            starve_cnt  <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_ready_i) begin
            state     <= IDLE;
            mem_req_o <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          mem_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_imem_dmem_port_arbiter
//
// Self-checking bench. A behavioural memory answers mem_req_o after a
// programmable number of cycles. Every grant pushes the expected memory
// fields and response into a scoreboard queue; the first mem_req_o cycle and
// each rvalid pulse are compared against the queue head.
// Inputs are driven 2 ns after posedge, outputs sampled at negedge.
// ---------------------------------------------------------------------------
module tb_imem_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        d_req_i = 1'b0;
  logic        d_we_i = 1'b0;
  logic [3:0]  d_be_i = '0;
  logic [31:0] d_addr_i = '0;
  logic [31:0] d_wdata_i = '0;
  logic        d_gnt_o, d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ready_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        busy_o;

  imem_dmem_port_arbiter #(
    .XLEN(32), .PC_WIDTH(32), .MAX_DATA_BURST(4)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i),
    .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o),
    .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- behavioural memory ----------------
  logic [31:0] mem [0:255];
  int          ready_delay  = 1;
  bit          spurious_req = 1'b0;

  initial begin : responder
    int  wait_cnt;
    bit  spurious_done;
    logic [7:0] a;
    wait_cnt = 0;
    spurious_done = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
    mem[1]   = 32'h0050_0093;
    mem[2]   = 32'h00A0_0113;
    mem[64]  = 32'hDEAD_BEEF;
    mem[128] = 32'h5555_5555;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        mem_ready_i = 1'b0;
        mem_rdata_i = '0;
        wait_cnt = 0;
      end else if (mem_ready_i) begin
        mem_ready_i = 1'b0;
        mem_rdata_i = '0;
      end else if (mem_req_o) begin
        wait_cnt++;
        if (wait_cnt >= ready_delay) begin
          a = mem_addr_o[9:2];
          mem_ready_i = 1'b1;
          mem_rdata_i = mem[a];
          if (mem_we_o) begin
            for (int b = 0; b < 4; b++)
              if (mem_be_o[b]) mem[a][8*b +: 8] = mem_wdata_o[8*b +: 8];
          end
          wait_cnt = 0;
        end
      end else if (spurious_req && !spurious_done) begin
        mem_ready_i = 1'b1;
        mem_rdata_i = 32'hCAFE_F00D;
        spurious_done = 1'b1;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  typedef struct {
    bit          port;   // 1 = data, 0 = fetch
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  bit   gnt_log[$];
  int   if_rv_cnt = 0;
  int   d_rv_cnt  = 0;

  always @(negedge clk) begin : monitor
    exp_t e;
    logic        prev_req;
    logic        s_we;
    logic [3:0]  s_be;
    logic [31:0] s_addr, s_wdata;
    if (rst) begin
      exp_q.delete();
      prev_req = 1'b0;
    end else begin
      chk("both_gnt", 32'(if_gnt_o & d_gnt_o), 32'd0);
      if (busy_o) chk("gnt_busy", 32'(if_gnt_o | d_gnt_o), 32'd0);
      if (d_gnt_o) begin
        e = '{1'b1, d_we_i, d_be_i, d_addr_i, d_wdata_i, mem[d_addr_i[9:2]]};
        exp_q.push_back(e);
        gnt_log.push_back(1'b1);
      end else if (if_gnt_o) begin
        e = '{1'b0, 1'b0, 4'hF, if_addr_i, 32'd0, mem[if_addr_i[9:2]]};
        exp_q.push_back(e);
        gnt_log.push_back(1'b0);
      end
      if (mem_req_o && !prev_req) begin
        if (exp_q.size() == 0) chk("req_unexp", 32'd1, 32'd0);
        else begin
          chk("mem_addr", mem_addr_o, exp_q[0].addr);
          chk("mem_we", 32'(mem_we_o), 32'(exp_q[0].we));
          chk("mem_be", 32'(mem_be_o), 32'(exp_q[0].be));
          chk("mem_wdata", mem_wdata_o, exp_q[0].wdata);
        end
        s_we = mem_we_o; s_be = mem_be_o; s_addr = mem_addr_o; s_wdata = mem_wdata_o;
      end else if (mem_req_o) begin
        chk("stable_addr", mem_addr_o, s_addr);
        chk("stable_ctl", {27'd0, s_we, s_be}, {27'd0, mem_we_o, mem_be_o});
        chk("stable_wdata", mem_wdata_o, s_wdata);
      end
      prev_req = mem_req_o;
      if (if_rvalid_o || d_rvalid_o) begin
        if (if_rvalid_o) if_rv_cnt++;
        if (d_rvalid_o)  d_rv_cnt++;
        if (exp_q.size() == 0) chk("rvalid_unexp", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("rv_owner_d", 32'(d_rvalid_o), 32'(e.port));
          chk("rv_owner_i", 32'(if_rvalid_o), 32'(!e.port));
          chk("rdata", e.port ? d_rdata_o : if_rdata_o, e.rdata);
          chk("rdata_other", e.port ? if_rdata_o : d_rdata_o, 32'd0);
        end
      end else begin
        chk("rdata_idle", if_rdata_o | d_rdata_o, 32'd0);
      end
    end
  end

  // ---------------- directed sequence ----------------
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic wait_gnts(input int n);
    for (int c = 0; c < 60; c++) begin
      if (gnt_log.size() >= n) return;
      tick();
    end
    chk("gnt_timeout", 32'(gnt_log.size()), 32'(n));
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 60; c++) begin
      if (exp_q.size() == 0 && !busy_o) return;
      tick();
    end
    chk("idle_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : main
    int base;
    int drv;
    bit pat [6];
    pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    // reset state
    @(negedge clk);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_memreq", 32'(mem_req_o), 32'd0);
    chk("rst_memfields", mem_addr_o | mem_wdata_o | 32'(mem_be_o) | 32'(mem_we_o), 32'd0);
    chk("rst_out", 32'(if_gnt_o | d_gnt_o | if_rvalid_o | d_rvalid_o), 32'd0);
    chk("rst_rdata", if_rdata_o | d_rdata_o, 32'd0);

    // single fetch, ready after 1 cycle
    tick();
    rst = 1'b0;
    if_req_i = 1'b1; if_addr_i = 32'h4;
    @(negedge clk);
    chk("t1_if_gnt", 32'(if_gnt_o), 32'd1);
    chk("t1_d_gnt", 32'(d_gnt_o), 32'd0);
    tick();
    if_req_i = 1'b0;
    @(negedge clk);
    chk("t1_memreq", 32'(mem_req_o), 32'd1);
    chk("t1_addr", mem_addr_o, 32'h4);
    chk("t1_be", 32'(mem_be_o), 32'hF);
    chk("t1_rvalid", 32'(if_rvalid_o), 32'd1);
    chk("t1_rdata", if_rdata_o, 32'h0050_0093);
    tick();
    @(negedge clk);
    chk("t1_idle", 32'(busy_o | mem_req_o), 32'd0);

    // simultaneous requests: data wins, fetch follows
    tick();
    if_req_i = 1'b1; if_addr_i = 32'h8;
    d_req_i = 1'b1; d_we_i = 1'b0; d_be_i = 4'hF; d_addr_i = 32'h100;
    @(negedge clk);
    chk("t2_d_gnt", 32'(d_gnt_o), 32'd1);
    chk("t2_if_gnt", 32'(if_gnt_o), 32'd0);
    tick();
    d_req_i = 1'b0;
    @(negedge clk);
    chk("t2_we", 32'(mem_we_o), 32'd0);
    chk("t2_d_rdata", d_rdata_o, 32'hDEAD_BEEF);
    chk("t2_if_rv", 32'(if_rvalid_o), 32'd0);
    tick();
    @(negedge clk);
    chk("t2_if_gnt_next", 32'(if_gnt_o), 32'd1);
    tick();
    if_req_i = 1'b0;
    wait_idle();

    // starvation guard: 4 data grants, then fetch, then data again
    base = gnt_log.size();
    if_req_i = 1'b1; if_addr_i = 32'h4;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h100;
    wait_gnts(base + 6);
    if_req_i = 1'b0; d_req_i = 1'b0;
    wait_idle();
    for (int k = 0; k < 6; k++)
      if (base + k < gnt_log.size())
        chk($sformatf("t3_order%0d", k), 32'(gnt_log[base + k]), 32'(pat[k]));

    // store with 3-cycle memory latency; fetch request while busy is ignored
    ready_delay = 3;
    drv = d_rv_cnt;
    base = gnt_log.size();
    d_req_i = 1'b1; d_we_i = 1'b1; d_be_i = 4'b0011;
    d_addr_i = 32'h200; d_wdata_i = 32'h1234_ABCD;
    wait_gnts(base + 1);
    d_req_i = 1'b0; d_addr_i = 32'h300;
    if_req_i = 1'b1;
    tick();
    if_req_i = 1'b0;
    wait_idle();
    tick(); tick();
    chk("t4_rv_count", 32'(d_rv_cnt - drv), 32'd1);
    chk("t4_gnt_count", 32'(gnt_log.size() - base), 32'd1);
    chk("t4_mem_word", mem[128], 32'h5555_ABCD);

    // reset while a load is in flight
    ready_delay = 5;
    drv = d_rv_cnt;
    base = gnt_log.size();
    d_req_i = 1'b1; d_we_i = 1'b0; d_be_i = 4'hF; d_addr_i = 32'h100;
    wait_gnts(base + 1);
    d_req_i = 1'b0;
    tick();
    chk("t5_busy_before", 32'(busy_o), 32'd1);
    rst = 1'b1;
    #1;
    chk("t5_memreq", 32'(mem_req_o), 32'd0);
    chk("t5_busy", 32'(busy_o), 32'd0);
    chk("t5_rv", 32'(d_rvalid_o | if_rvalid_o), 32'd0);
    chk("t5_memaddr", mem_addr_o, 32'd0);
    tick();
    rst = 1'b0;
    ready_delay = 1;
    chk("t5_no_rv", 32'(d_rv_cnt - drv), 32'd0);
    base = gnt_log.size();
    if_req_i = 1'b1; if_addr_i = 32'h8;
    wait_gnts(base + 1);
    if_req_i = 1'b0;
    wait_idle();
    if (base < gnt_log.size()) chk("t5_fetch_gnt", 32'(gnt_log[base]), 32'd0);

    // spurious mem_ready_i while idle
    drv = d_rv_cnt + if_rv_cnt;
    spurious_req = 1'b1;
    tick(); tick(); tick();
    chk("t6_no_rv", 32'(d_rv_cnt + if_rv_cnt - drv), 32'd0);
    chk("t6_idle", 32'(busy_o), 32'd0);
    chk("t6_q_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
